// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, opcodes, ALU op encodings
// and the hazard controller state type.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [5:0] OP_SUB = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000010;
    localparam logic [5:0] OP_SW  = 6'b000011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
// Kept standalone so a later forwarding unit can reuse it.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  lu_hit
);

    // r0 is hard-wired to zero, so a load into it never creates a dependency.
    assign lu_hit = id_valid && ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use bubble insertion and data-memory req/ack sequencing for the 5-stage pipe.
// Optional macro DMEM_TIMEOUT_EN adds a forced release after TIMEOUT_CYC wait cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_memread,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   mem_memread,
    input  logic                   mem_memwrite,
    input  logic                   dmem_ack,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   idex_bubble,
    output logic                   pipe_hold,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic                   dmem_timeout
`endif
);

    ctrl_state_t state_q, state_d;
    logic req_q, req_d;
    logic we_q, we_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic lu_hit;
    logic mem_op;
    logic mem_done;

    load_use_detect u_load_use_detect (
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread),
        .ex_rt     (ex_rt),
        .lu_hit    (lu_hit)
    );

    assign mem_op = mem_memread | mem_memwrite;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic timeout_hit;

    // An ack arriving on the last allowed cycle wins over the timeout.
    assign timeout_hit = (state_q == MEM_WAIT) && !dmem_ack &&
                         (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
    assign mem_done     = dmem_ack | timeout_hit;
    assign dmem_timeout = timeout_hit & ~rst;

    always_comb begin
        wait_d = '0;
        if (state_q == MEM_WAIT) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign mem_done = dmem_ack;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    // Memory hold wins; a pending load-use is re-evaluated on release.
                    if (mem_op) begin
                        state_d    = MEM_WAIT;
                        req_d      = 1'b1;
                        we_d       = mem_memwrite;
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end else if (lu_hit) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pipe_hold  = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (mem_done) begin
                        pipe_hold   = 1'b0;
                        pc_write    = !lu_hit;
                        ifid_write  = !lu_hit;
                        idex_bubble = lu_hit;
                        state_d     = IDLE;
                        req_d       = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; narrow stall counter so saturation is reachable.
// Timeout scenario runs when DMEM_TIMEOUT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int SW = 4;
    localparam int OW = SW + 6;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_uses_rt, ex_memread, mem_memread, mem_memwrite, dmem_ack;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic pc_write, ifid_write, idex_bubble, pipe_hold, dmem_req, dmem_we;
    logic [SW-1:0] stall_cycles;
`ifdef DMEM_TIMEOUT_EN
    logic dmem_timeout;
`endif

    logic [OW-1:0] sb[$];
    logic [OW-1:0] obs, exp_v;
    int n_checks = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(
        .STALL_CNT_W(SW)
`ifdef DMEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .mem_memread (mem_memread),
        .mem_memwrite(mem_memwrite),
        .dmem_ack    (dmem_ack),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_bubble (idex_bubble),
        .pipe_hold   (pipe_hold),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .stall_cycles(stall_cycles)
`ifdef DMEM_TIMEOUT_EN
        ,
        .dmem_timeout(dmem_timeout)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Packed expectation; write strobe only matters while a request is up.
    function automatic logic [OW-1:0] ex(input bit pc, input bit ifid, input bit bub,
                                         input bit hold, input bit req, input bit we,
                                         input int st);
        return {pc, ifid, bub, hold, req, req ? we : 1'b0, SW'(st)};
    endfunction

    function automatic logic [OW-1:0] snap();
        return {pc_write, ifid_write, idex_bubble, pipe_hold, dmem_req,
                dmem_req ? dmem_we : 1'b0, stall_cycles};
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                         input bit exm, input int exrt, input bit mr, input bit mw,
                         input bit ack);
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_uses_rt   = urt;
        ex_memread   = exm;
        ex_rt        = 5'(exrt);
        mem_memread  = mr;
        mem_memwrite = mw;
        dmem_ack     = ack;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 5, 1, 1, 5, 1, 0, 0);
        next_cycle();
        sb.push_back(ex(1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        obs = snap(); exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL reset_hold: got %b want %b", obs, exp_v);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            sb.push_back(ex(1, 1, 0, 0, 0, 0, 0));
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin drive(1, 5, 0, 1, 1, 5, 0, 0, 0); sb.push_back(ex(0, 0, 1, 0, 0, 0, 0)); end
                1: begin drive(1, 5, 0, 1, 0, 5, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 1)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 1)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL load_use cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin drive(1, 0, 0, 1, 1, 0, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 0)); end
                1: begin drive(1, 3, 5, 0, 1, 5, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 0)); end
                2: begin drive(1, 3, 5, 1, 1, 5, 0, 0, 0); sb.push_back(ex(0, 0, 1, 0, 0, 0, 0)); end
                default: begin drive(0, 3, 5, 1, 1, 5, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 1)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL no_hazard cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_sw_handshake();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(ex(0, 0, 0, 1, 0, 0, 0)); end
                1: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(ex(0, 0, 0, 1, 1, 1, 1)); end
                2: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(ex(0, 0, 0, 1, 1, 1, 2)); end
                3: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); sb.push_back(ex(1, 1, 0, 0, 1, 1, 3)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 3)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL sw_handshake cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_lw_priority();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin drive(1, 7, 0, 1, 1, 7, 1, 0, 0); sb.push_back(ex(0, 0, 0, 1, 0, 0, 0)); end
                1: begin drive(1, 7, 0, 1, 1, 7, 1, 0, 1); sb.push_back(ex(0, 0, 1, 0, 1, 0, 1)); end
                default: begin drive(1, 7, 0, 1, 0, 7, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 2)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL lw_priority cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1); sb.push_back(ex(1, 1, 0, 0, 0, 0, 0)); end
                1: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back(ex(0, 0, 0, 1, 0, 0, 0)); end
                2: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 1); sb.push_back(ex(1, 1, 0, 0, 1, 0, 1)); end
                3: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(ex(0, 0, 0, 1, 0, 0, 1)); end
                4: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); sb.push_back(ex(1, 1, 0, 0, 1, 1, 2)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 2)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back(ex(0, 0, 0, 1, 0, 0, 0)); end
                1: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back(ex(0, 0, 0, 1, 1, 0, 1)); end
                2: begin rst = 1'b1; sb.push_back(ex(1, 1, 0, 0, 1, 0, 2)); end
                3: begin
                    rst = 1'b0;
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
                    sb.push_back(ex(1, 1, 0, 0, 0, 0, 0));
                end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(ex(1, 1, 0, 0, 0, 0, 0)); end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            if (i < 20) begin
                drive(1, 4, 0, 0, 1, 4, 0, 0, 0);
                sb.push_back(ex(0, 0, 1, 0, 0, 0, (i < 15) ? i : 15));
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                sb.push_back(ex(1, 1, 0, 0, 0, 0, 15));
            end
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL saturation cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_to;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp_to = 1'b0;
            case (i)
                0, 6: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
                    sb.push_back(ex(0, 0, 0, 1, 0, 0, (i == 0) ? 0 : 4));
                end
                1, 2, 3: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
                    sb.push_back(ex(0, 0, 0, 1, 1, 0, i));
                end
                4: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
                    sb.push_back(ex(1, 1, 0, 0, 1, 0, 4));
                    exp_to = 1'b1;
                end
                7, 8, 9: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
                    sb.push_back(ex(0, 0, 0, 1, 1, 0, i - 2));
                end
                10: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
                    sb.push_back(ex(1, 1, 0, 0, 1, 0, 8));
                end
                default: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                    sb.push_back(ex(1, 1, 0, 0, 0, 0, (i == 5) ? 4 : 8));
                end
            endcase
            @(negedge clk);
            obs = snap(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL timeout cyc %0d: got %b want %b", i, obs, exp_v);
            else n_pass++;
            n_checks++;
            if (dmem_timeout !== exp_to)
                $display("FAIL timeout_pulse cyc %0d: got %b want %b", i, dmem_timeout, exp_to);
            else n_pass++;
            next_cycle();
        end
    endtask
`endif

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_sw_handshake();
        test_lw_priority();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
